// File: rtl/st7789_pkg.sv
// Shared ST7789 command codes, packer FSM states and the RGB888 -> RGB565 reduction.
package st7789_pkg;

  localparam logic [7:0] ST7789_CASET = 8'h2A;
  localparam logic [7:0] ST7789_RASET = 8'h2B;
  localparam logic [7:0] ST7789_RAMWR = 8'h2C;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PIX_HI,
    PIX_LO
  } state_t;

  // Keep the top bits of each channel: R[7:3], G[7:2], B[7:3].
  function automatic logic [15:0] rgb888_to_rgb565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction

endpackage

// File: rtl/st7789_frame_packer.sv
// Packs an RGB888 pixel stream into an ST7789 byte stream: a CASET/RASET/RAMWR window
// header per frame, then two RGB565 bytes per pixel, with command bytes flagged on TUSER.
module st7789_frame_packer
  import st7789_pkg::*;
#(
  parameter int H_RES    = 240,
  parameter int V_RES    = 240,
  parameter int X_OFFSET = 0,
  parameter int Y_OFFSET = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [23:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TUSER,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  output logic [7:0]  M_AXIS_TDATA,
  output logic        M_AXIS_TKEEP,
  output logic        M_AXIS_TUSER,
  output logic        M_AXIS_TVALID,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  output logic        BUSY,
  output logic        FRAME_ERR
);

  localparam int              NPIX     = H_RES * V_RES;
  localparam int              CNT_W    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);
  localparam logic [15:0]     XS       = 16'(X_OFFSET);
  localparam logic [15:0]     XE       = 16'(X_OFFSET + H_RES - 1);
  localparam logic [15:0]     YS       = 16'(Y_OFFSET);
  localparam logic [15:0]     YE       = 16'(Y_OFFSET + V_RES - 1);
  localparam logic [3:0]      HDR_LAST = 4'd10;

  state_t           state, state_d;
  logic [CNT_W-1:0] pix_cnt, pix_cnt_d;
  logic [3:0]       hdr_idx, hdr_idx_d;
  logic [7:0]       lo_byte, lo_byte_d;
  logic [7:0]       tdata_d;
  logic             tvalid_d, tuser_d, tlast_d, frame_err_d;
  logic             s_ready;
  logic             out_free;
  logic [15:0]      rgb565;
  logic [7:0]       hdr_byte;
  logic             hdr_is_cmd;
  logic             last_pix;

  assign out_free   = !M_AXIS_TVALID || M_AXIS_TREADY;
  assign rgb565     = rgb888_to_rgb565(S_AXIS_TDATA);
  assign hdr_is_cmd = (hdr_idx == 4'd0) || (hdr_idx == 4'd5) || (hdr_idx == HDR_LAST);
  assign last_pix   = (pix_cnt == LAST_PIX);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    hdr_byte = ST7789_RAMWR;
    case (hdr_idx)
      4'd0:    hdr_byte = ST7789_CASET;
      4'd1:    hdr_byte = XS[15:8];
      4'd2:    hdr_byte = XS[7:0];
      4'd3:    hdr_byte = XE[15:8];
      4'd4:    hdr_byte = XE[7:0];
      4'd5:    hdr_byte = ST7789_RASET;
      4'd6:    hdr_byte = YS[15:8];
      4'd7:    hdr_byte = YS[7:0];
      4'd8:    hdr_byte = YE[15:8];
      4'd9:    hdr_byte = YE[7:0];
      default: hdr_byte = ST7789_RAMWR;
    endcase
  end

  always_comb begin
    state_d     = state;
    pix_cnt_d   = pix_cnt;
    hdr_idx_d   = hdr_idx;
    lo_byte_d   = lo_byte;
    tdata_d     = M_AXIS_TDATA;
    tuser_d     = M_AXIS_TUSER;
    tvalid_d    = M_AXIS_TVALID && !M_AXIS_TREADY;
    tlast_d     = M_AXIS_TLAST && tvalid_d;
    frame_err_d = 1'b0;
    s_ready     = 1'b0;

    case (state)
      IDLE: begin
        // Non-SOF pixels are swallowed; the SOF pixel waits on the bus for PIX_HI.
        s_ready = !(S_AXIS_TVALID && S_AXIS_TUSER);
        if (S_AXIS_TVALID && S_AXIS_TUSER && ENABLE) state_d = HDR;
      end
      HDR: begin
        if (out_free) begin
          tvalid_d = 1'b1;
          tdata_d  = hdr_byte;
          tuser_d  = hdr_is_cmd;
          tlast_d  = 1'b0;
          if (hdr_idx == HDR_LAST) begin
            hdr_idx_d = '0;
            state_d   = PIX_HI;
          end else begin
            hdr_idx_d = hdr_idx + 4'd1;
          end
        end
      end
      PIX_HI: begin
        s_ready = out_free;
        if (S_AXIS_TVALID && out_free) begin
          tvalid_d    = 1'b1;
          tdata_d     = rgb565[15:8];
          tuser_d     = 1'b0;
          tlast_d     = 1'b0;
          lo_byte_d   = rgb565[7:0];
          state_d     = PIX_LO;
          frame_err_d = (S_AXIS_TUSER && (pix_cnt != '0)) || (S_AXIS_TLAST != last_pix);
        end
      end
      PIX_LO: begin
        if (out_free) begin
          tvalid_d = 1'b1;
          tdata_d  = lo_byte;
          tuser_d  = 1'b0;
          tlast_d  = last_pix;
          if (last_pix) begin
            pix_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            pix_cnt_d = pix_cnt + 1'b1;
            state_d   = PIX_HI;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (RESET) begin
      state         <= IDLE;
      pix_cnt       <= '0;
      hdr_idx       <= '0;
      lo_byte       <= '0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TUSER  <= 1'b0;
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      FRAME_ERR     <= 1'b0;
    end else begin
      state         <= state_d;
      pix_cnt       <= pix_cnt_d;
      hdr_idx       <= hdr_idx_d;
      lo_byte       <= lo_byte_d;
      M_AXIS_TDATA  <= tdata_d;
      M_AXIS_TUSER  <= tuser_d;
      M_AXIS_TVALID <= tvalid_d;
      M_AXIS_TLAST  <= tlast_d;
      FRAME_ERR     <= frame_err_d;
    end
  end

  // TREADY is combinational, so it is gated while reset is held.
  assign S_AXIS_TREADY = s_ready && !RESET;
  assign M_AXIS_TKEEP  = M_AXIS_TVALID;
  assign BUSY          = (state != IDLE);

endmodule

// File: tb/tb_st7789_frame_packer.sv
// Randomized self-checking bench for st7789_frame_packer against a byte-stream reference model.
module tb_st7789_frame_packer;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int N  = H * V;
  localparam int XO = 34;
  localparam int YO = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance (4x2) used by most tests.
  logic        rst, en;
  logic [23:0] s_tdata;
  logic        s_tuser, s_tlast, s_tvalid, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tkeep, m_tuser, m_tvalid, m_tlast, m_tready;
  logic        busy, frame_err;

  // Full-size instance used for the 240x240 header.
  logic        b_rst, b_en;
  logic [23:0] b_tdata;
  logic        b_tuser, b_tlast, b_tvalid, b_tready;
  logic [7:0]  b_mdata;
  logic        b_mkeep, b_muser, b_mvalid, b_mlast, b_mready;
  logic        b_busy, b_err;

  st7789_frame_packer #(.H_RES(H), .V_RES(V), .X_OFFSET(XO), .Y_OFFSET(YO)) dut (
    .CLK(clk), .RESET(rst), .ENABLE(en),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TUSER(s_tuser), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TKEEP(m_tkeep), .M_AXIS_TUSER(m_tuser),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready),
    .BUSY(busy), .FRAME_ERR(frame_err)
  );

  st7789_frame_packer #(.H_RES(240), .V_RES(240), .X_OFFSET(0), .Y_OFFSET(80)) dut_big (
    .CLK(clk), .RESET(b_rst), .ENABLE(b_en),
    .S_AXIS_TDATA(b_tdata), .S_AXIS_TUSER(b_tuser), .S_AXIS_TLAST(b_tlast),
    .S_AXIS_TVALID(b_tvalid), .S_AXIS_TREADY(b_tready),
    .M_AXIS_TDATA(b_mdata), .M_AXIS_TKEEP(b_mkeep), .M_AXIS_TUSER(b_muser),
    .M_AXIS_TVALID(b_mvalid), .M_AXIS_TLAST(b_mlast), .M_AXIS_TREADY(b_mready),
    .BUSY(b_busy), .FRAME_ERR(b_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Captured and expected bytes are {tuser, tlast, data}.
  logic [9:0]  got_q[$];
  logic [9:0]  exp_q[$];
  logic [9:0]  big_q[$];
  int          err_seen = 0;
  bit          bp = 1'b0;
  logic        stall = 1'b0;
  logic [9:0]  stall_word = '0;

  logic [23:0] pix[N];
  bit          pu[N];
  bit          pl[N];

  always @(negedge clk) begin
    if (!rst) begin
      if (stall && m_tvalid) check("stable", {m_tuser, m_tlast, m_tdata}, stall_word);
      if (m_tvalid && m_tready) begin
        check("tkeep", m_tkeep, 1);
        got_q.push_back({m_tuser, m_tlast, m_tdata});
      end
      if (frame_err) err_seen++;
    end
    stall      = m_tvalid && !m_tready && !rst;
    stall_word = {m_tuser, m_tlast, m_tdata};
    if (!b_rst && b_mvalid && b_mready) big_q.push_back({b_muser, b_mlast, b_mdata});
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference model: window header from the offsets, then RGB565 bytes by plain arithmetic.
  function automatic logic [7:0] hdr_ref(input int k);
    int xs, xe, ys, ye;
    xs = XO; xe = XO + H - 1; ys = YO; ye = YO + V - 1;
    case (k)
      0:       return 8'h2A;
      1:       return 8'(xs / 256);
      2:       return 8'(xs % 256);
      3:       return 8'(xe / 256);
      4:       return 8'(xe % 256);
      5:       return 8'h2B;
      6:       return 8'(ys / 256);
      7:       return 8'(ys % 256);
      8:       return 8'(ye / 256);
      9:       return 8'(ye % 256);
      default: return 8'h2C;
    endcase
  endfunction

  task automatic build_expected(output int exp_err);
    int r, g, b, hi, lo;
    exp_q.delete();
    exp_err = 0;
    for (int k = 0; k < 11; k++) exp_q.push_back({(k == 0 || k == 5 || k == 10), 1'b0, hdr_ref(k)});
    for (int i = 0; i < N; i++) begin
      r  = int'(pix[i] >> 16) & 255;
      g  = int'(pix[i] >> 8) & 255;
      b  = int'(pix[i]) & 255;
      hi = (r / 8) * 8 + g / 32;
      lo = ((g / 4) % 8) * 32 + b / 8;
      exp_q.push_back({1'b0, 1'b0, 8'(hi)});
      exp_q.push_back({1'b0, (i == N - 1), 8'(lo)});
      if ((pu[i] && i != 0) || (pl[i] && i != N - 1) || (!pl[i] && i == N - 1)) exp_err++;
    end
  endtask

  task automatic random_frame();
    for (int i = 0; i < N; i++) begin
      pix[i] = 24'($urandom);
      pu[i]  = (i == 0);
      pl[i]  = (i == N - 1);
    end
  endtask

  task automatic wait_accept();
    int t = 0;
    @(negedge clk);
    while (!s_tready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!s_tready) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_pixel(input int i);
    s_tdata  = pix[i];
    s_tuser  = pu[i];
    s_tlast  = pl[i];
    s_tvalid = 1'b1;
    wait_accept();
  endtask

  task automatic finish_frame(input string tag, input int exp_err);
    int t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("%s_b%0d", tag, k), got_q[k], exp_q[k]);
    check({tag, "_frame_err"}, err_seen, exp_err);
    check({tag, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag);
    int exp_err;
    build_expected(exp_err);
    got_q.delete();
    err_seen = 0;
    for (int i = 0; i < N; i++) send_pixel(i);
    finish_frame(tag, exp_err);
  endtask

  logic [9:0] big_exp[13] = '{10'h22A, 10'h000, 10'h000, 10'h000, 10'h0EF,
                              10'h22B, 10'h000, 10'h050, 10'h001, 10'h03F,
                              10'h22C, 10'h0FC, 10'h008};

  initial begin
    int t;
    int exp_err;
    rst = 1'b1; en = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0; s_tvalid = 1'b0;
    b_rst = 1'b1; b_en = 1'b0; b_tdata = '0; b_tuser = 1'b0; b_tlast = 1'b0; b_tvalid = 1'b0;
    b_mready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tuser", m_tuser, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_tkeep", m_tkeep, 0);
    check("rst_sready", s_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; b_rst = 1'b0;

    // 240x240 header with Y offset 80.
    b_en = 1'b1; b_tdata = 24'hFF8040; b_tuser = 1'b1; b_tvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!b_tready && t < 100) begin @(negedge clk); t++; end
    if (!b_tready) check("big_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    b_tvalid = 1'b0;
    t = 0;
    while (big_q.size() < 13 && t < 100) begin @(negedge clk); t++; end
    check("big_len", big_q.size() >= 13, 1);
    for (int k = 0; k < 13 && k < big_q.size(); k++) check($sformatf("big_b%0d", k), big_q[k], big_exp[k]);
    b_rst = 1'b1;

    // Colour conversion with fixed leading pixels and a free-flowing sink.
    en = 1'b1;
    random_frame();
    pix[0] = 24'hFF8040;
    pix[1] = 24'h0000FF;
    run_frame("colour");
    if (got_q.size() >= 15) begin
      check("colour_hi0", got_q[11], 10'h0FC);
      check("colour_lo0", got_q[12], 10'h008);
      check("colour_hi1", got_q[13], 10'h000);
      check("colour_lo1", got_q[14], 10'h01F);
    end else check("colour_short", got_q.size(), 15);

    // Same frame under random 30% sink readiness.
    bp = 1'b1;
    run_frame("backpressure");
    bp = 1'b0;
    @(posedge clk);
    #1;

    // Idle gating: non-SOF pixels dropped, SOF held while disabled.
    en = 1'b0;
    got_q.delete();
    for (int i = 0; i < 3; i++) begin
      s_tdata = 24'($urandom); s_tuser = 1'b0; s_tlast = 1'b0; s_tvalid = 1'b1;
      @(negedge clk);
      check("drop_ready", s_tready, 1);
      @(posedge clk);
      #1;
    end
    random_frame();
    build_expected(exp_err);
    err_seen = 0;
    s_tdata = pix[0]; s_tuser = 1'b1; s_tlast = 1'b0; s_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_ready", s_tready, 0);
      check("hold_busy", busy, 0);
      @(posedge clk);
      #1;
    end
    check("gate_no_output", got_q.size(), 0);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("gate_busy", busy, 1);
    wait_accept();
    for (int i = 1; i < N; i++) send_pixel(i);
    finish_frame("gate", exp_err);

    // Framing errors: early TLAST on pixel 5, missing TLAST on pixel 7.
    random_frame();
    pl[5] = 1'b1;
    pl[7] = 1'b0;
    run_frame("framing");

    // Reset in the middle of a frame.
    random_frame();
    build_expected(exp_err);
    for (int i = 0; i < 4; i++) send_pixel(i);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_tdata", m_tdata, 0);
    check("mid_rst_tlast", m_tlast, 0);
    check("mid_rst_tuser", m_tuser, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_err", frame_err, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", s_tready, 1);
    @(posedge clk);
    #1;
    random_frame();
    pu[2] = 1'b1;
    run_frame("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/st7789_frame_packer.md
Name: st7789_frame_packer

Overview:
- Upstream stage feeding st7789_driver's byte stream.
- Takes a 24-bit RGB888 pixel AXI-Stream and prefixes every frame with the ST7789 window commands CASET (0x2A), RASET (0x2B) and RAMWR (0x2C).
- Converts each pixel to two RGB565 bytes and emits commands and data as one byte stream.
- Command bytes are flagged via TUSER, so the driver can set LCD_DC.

Parameters:
- H_RES, 240, active columns per frame.
- V_RES, 240, active lines per frame.
- X_OFFSET, 0, first panel column written (CASET start).
- Y_OFFSET, 0, first panel row written (RASET start).

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- ENABLE  in  1  permits a new frame to start
- S_AXIS_TDATA  in  24  pixel {R[23:16],G[15:8],B[7:0]}
- S_AXIS_TUSER  in  1  start-of-frame marker on first pixel
- S_AXIS_TLAST  in  1  end-of-frame marker on last pixel
- S_AXIS_TVALID  in  1  pixel valid
- S_AXIS_TREADY  out  1  pixel accepted when high with TVALID
- M_AXIS_TDATA  out  8  byte to driver
- M_AXIS_TKEEP  out  1  equals M_AXIS_TVALID
- M_AXIS_TUSER  out  1  1 = command byte (DC low), 0 = parameter/pixel byte
- M_AXIS_TVALID  out  1  byte valid
- M_AXIS_TLAST  out  1  last byte of frame (low byte of final pixel)
- M_AXIS_TREADY  in  1  driver ready
- BUSY  out  1  frame in progress (state != IDLE)
- FRAME_ERR  out  1  one-cycle pulse on input framing mismatch

Behaviour:
- Reset values: all M_AXIS_* outputs 0, S_AXIS_TREADY 0, BUSY 0, FRAME_ERR 0. State is IDLE, pixel counter 0, header index 0.
- Reset mid-frame aborts immediately; no partial frame resumes. The next frame requires a new SOF.
- Output stage is a single register. out_free = !M_AXIS_TVALID || M_AXIS_TREADY. A byte is loaded only when out_free is high; M_AXIS_TVALID clears when the byte is taken and nothing new loads. Output holds stable under backpressure.
- IDLE:
  - S_AXIS_TREADY = 1. Pixels with TUSER=0 are dropped.
  - A pixel with TUSER=1 is not accepted while ENABLE=1; TREADY drops to 0 for it. The FSM moves to HDR, which is entered only while ENABLE=1.
  - With ENABLE=0, the SOF pixel is held (TREADY=0) and the FSM stays in IDLE.
- HDR: emits 11 bytes, one per out_free cycle.
  - 0x2A (TUSER=1), XS[15:8], XS[7:0], XE[15:8], XE[7:0]
  - 0x2B (TUSER=1), YS[15:8], YS[7:0], YE[15:8], YE[7:0]
  - 0x2C (TUSER=1)
  - XS = X_OFFSET, XE = X_OFFSET+H_RES-1, YS = Y_OFFSET, YE = Y_OFFSET+V_RES-1, all 16-bit unsigned.
  - S_AXIS_TREADY = 0 throughout. After the last header byte the FSM moves to PIX_HI.
- PIX_HI:
  - S_AXIS_TREADY = out_free.
  - On accept, load M_AXIS_TDATA = {R[7:3],G[7:5]} with TUSER=0, latch lo = {G[4:2],B[7:3]}, and go to PIX_LO.
- PIX_LO:
  - S_AXIS_TREADY = 0.
  - When out_free, load lo and increment the pixel counter.
  - If counter == H_RES*V_RES-1: set TLAST=1, reset counter, go to IDLE. Otherwise go to PIX_HI.
- Throughput: 1 pixel per 2 cycles max. Latency: accept to M_AXIS_TVALID = 1 cycle.
- FRAME_ERR pulses (1 cycle) when:
  - an accepted pixel has TUSER=1 other than the first pixel of the frame (pixel is still used), or
  - an accepted pixel has TLAST=1 when it is not pixel H_RES*V_RES-1, or
  - the final pixel arrives with TLAST=0.
- Framing errors never alter the count; frame length is always H_RES*V_RES pixels.
- ENABLE is sampled only in IDLE; deasserting it mid-frame has no effect until IDLE.
- Counter width: $clog2(H_RES*V_RES).

Decomposition:
- Package st7789_pkg holds:
  - command constants ST7789_CASET=8'h2A, ST7789_RASET=8'h2B, ST7789_RAMWR=8'h2C;
  - typedef enum for states IDLE/HDR/PIX_HI/PIX_LO;
  - function rgb888_to_rgb565 returning 16 bits.
- No sub-module. The output register stays inline; a separate skid buffer is not needed.

Test Plan:
- Header, H_RES=240 V_RES=240 X_OFFSET=0 Y_OFFSET=80, M_TREADY=1, SOF pixel -> bytes 2A(u=1),00,00,00,EF,2B(u=1),00,50,01,3F,2C(u=1), then pixel bytes with u=0.
- Colour, H_RES=4 V_RES=2, pixel 0xFF8040 -> bytes 0xFC,0x08. Pixel 0x0000FF -> 0x00,0x1F. TLAST only on byte 16 of the pixel section.
- Backpressure: random M_AXIS_TREADY 30% duty -> byte sequence identical to the M_TREADY=1 run; TDATA stable while TVALID && !TREADY.
- Idle gating: 3 pixels with TUSER=0, then a SOF pixel with ENABLE=0 -> first 3 dropped, SOF held (TREADY=0), no output. Raise ENABLE -> header starts the next cycle.
- Framing, 4x2: TLAST on pixel 5 -> FRAME_ERR pulse, frame still emits 8 pixels. No TLAST on pixel 7 -> second pulse.
- Reset mid-frame: RESET at pixel 3 -> next cycle all outputs 0, BUSY 0. A following SOF frame emits a full header.
